// File: rtl/sad_accum_if.sv
// Pixel-pair stream between the reference fetch and the SAD accumulator.
// The fetch side reads cand_idx/pix_idx to address the next reference pixel.
interface sad_accum_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] cur_pix;
    logic [PIX_W-1:0] ref_pix;
    logic [3:0]       cand_idx;
    logic [3:0]       pix_idx;

    modport master (
        output in_valid, cur_pix, ref_pix,
        input  in_ready, cand_idx, pix_idx
    );

    modport slave (
        input  in_valid, cur_pix, ref_pix,
        output in_ready, cand_idx, pix_idx
    );
endinterface

// File: rtl/sad_accum.sv
// 4x4 block SAD engine: accumulates 16 candidates serially (candidate-major,
// raster pixel order) and holds one registered SAD per candidate.

module sad_lane #(
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [SUM_W-1:0] d,
    output logic [SUM_W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (wr) q <= d;
    end
endmodule

module sad_accum #(
    parameter int PIX_W = 8,
    // SUM_W >= PIX_W+4 keeps 16 maximal differences from wrapping
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    sad_accum_if.slave       pix,
    output logic [SUM_W-1:0] sum0,
    output logic [SUM_W-1:0] sum1,
    output logic [SUM_W-1:0] sum2,
    output logic [SUM_W-1:0] sum3,
    output logic [SUM_W-1:0] sum4,
    output logic [SUM_W-1:0] sum5,
    output logic [SUM_W-1:0] sum6,
    output logic [SUM_W-1:0] sum7,
    output logic [SUM_W-1:0] sum8,
    output logic [SUM_W-1:0] sum9,
    output logic [SUM_W-1:0] sum10,
    output logic [SUM_W-1:0] sum11,
    output logic [SUM_W-1:0] sum12,
    output logic [SUM_W-1:0] sum13,
    output logic [SUM_W-1:0] sum14,
    output logic [SUM_W-1:0] sum15,
    output logic             busy,
    output logic             done
);
    localparam int NUM_CAND = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                          state;
    logic                            in_ready_q;
    logic [3:0]                      cand_q;
    logic [3:0]                      pidx_q;
    logic [SUM_W-1:0]                acc_q;
    logic [PIX_W:0]                  diff;
    logic [SUM_W-1:0]                acc_sum;
    logic                            fire;
    logic                            last_pix;
    logic [NUM_CAND-1:0]             lane_wr;
    logic [NUM_CAND-1:0][SUM_W-1:0]  sum_q;

    assign pix.in_ready = in_ready_q;
    assign pix.cand_idx = cand_q;
    assign pix.pix_idx  = pidx_q;

    always_comb begin
        diff = '0;
        if (pix.cur_pix >= pix.ref_pix) diff = {1'b0, pix.cur_pix} - {1'b0, pix.ref_pix};
        else                            diff = {1'b0, pix.ref_pix} - {1'b0, pix.cur_pix};
    end

    assign acc_sum  = acc_q + SUM_W'(diff);
    // abort wins over a beat presented in the same cycle
    assign fire     = pix.in_valid && in_ready_q && !abort;
    assign last_pix = (pidx_q == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cand_q     <= '0;
            pidx_q     <= '0;
            acc_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= ACCUM;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        cand_q     <= '0;
                        pidx_q     <= '0;
                        acc_q      <= '0;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                        cand_q     <= '0;
                        pidx_q     <= '0;
                        acc_q      <= '0;
                    end else if (fire) begin
                        if (last_pix) begin
                            acc_q  <= '0;
                            pidx_q <= '0;
                            cand_q <= cand_q + 4'd1;
                            if (cand_q == 4'hF) begin
                                state      <= DONE;
                                in_ready_q <= 1'b0;
                                done       <= 1'b1;
                            end
                        end else begin
                            acc_q  <= acc_sum;
                            pidx_q <= pidx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    // One register lane per candidate; only the completing candidate is written.
    for (genvar i = 0; i < NUM_CAND; i++) begin : g_lane
        assign lane_wr[i] = fire && last_pix && (cand_q == 4'(i));
        sad_lane #(.SUM_W(SUM_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (lane_wr[i]),
            .d     (acc_sum),
            .q     (sum_q[i])
        );
    end

    assign sum0  = sum_q[0];
    assign sum1  = sum_q[1];
    assign sum2  = sum_q[2];
    assign sum3  = sum_q[3];
    assign sum4  = sum_q[4];
    assign sum5  = sum_q[5];
    assign sum6  = sum_q[6];
    assign sum7  = sum_q[7];
    assign sum8  = sum_q[8];
    assign sum9  = sum_q[9];
    assign sum10 = sum_q[10];
    assign sum11 = sum_q[11];
    assign sum12 = sum_q[12];
    assign sum13 = sum_q[13];
    assign sum14 = sum_q[14];
    assign sum15 = sum_q[15];
endmodule

// File: tb/tb_sad_accum.sv
// Directed bench for sad_accum: block patterns, stalls, abort, start handling, async reset.
module tb_sad_accum;
    localparam int PIX_W = 8;
    localparam int SUM_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;
    logic [SUM_W-1:0] sums [16];

    int errors = 0;
    int checks = 0;

    sad_accum_if #(.PIX_W(PIX_W)) pix ();

    sad_accum #(.PIX_W(PIX_W), .SUM_W(SUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .pix   (pix.slave),
        .sum0  (sums[0]),  .sum1  (sums[1]),  .sum2  (sums[2]),  .sum3  (sums[3]),
        .sum4  (sums[4]),  .sum5  (sums[5]),  .sum6  (sums[6]),  .sum7  (sums[7]),
        .sum8  (sums[8]),  .sum9  (sums[9]),  .sum10 (sums[10]), .sum11 (sums[11]),
        .sum12 (sums[12]), .sum13 (sums[13]), .sum14 (sums[14]), .sum15 (sums[15]),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Pixel patterns: 0 flat, 1 ref=c, 2 cur=FF/ref=00, 3 swapped, 4 cur=p/ref=c
    function automatic void gen_pix(input int mode, input int c, input int p,
                                    output logic [7:0] cu, output logic [7:0] rf);
        case (mode)
            0:       begin cu = 8'h40; rf = 8'h40;   end
            1:       begin cu = 8'h00; rf = 8'(c);   end
            2:       begin cu = 8'hFF; rf = 8'h00;   end
            3:       begin cu = 8'h00; rf = 8'hFF;   end
            default: begin cu = 8'(p); rf = 8'(c);   end
        endcase
    endfunction

    function automatic int exp_sum(input int mode, input int c);
        case (mode)
            0:       return 0;
            1:       return 16 * c;
            2, 3:    return 4080;
            default: return c * (c + 1) / 2 + (15 - c) * (16 - c) / 2;
        endcase
    endfunction

    // Stimulus driver: cycle 1 is the start cycle; done is expected in cycle 258.
    task automatic drive_block(input int mode, input bit stalls, input int stop_at, input int poke_at,
                               output int done_cyc, output int pulses, output int idx_err,
                               output logic busy_at_done);
        int beat, cyc, s17, s200;
        logic v;
        logic [7:0] cu, rf;
        beat = 0; s17 = 0; s200 = 0;
        done_cyc = 0; pulses = 0; idx_err = 0; busy_at_done = 1'b0;
        @(negedge clk); start = 1'b1; pix.in_valid = 1'b0;
        @(negedge clk); start = 1'b0; cyc = 2;
        while (cyc < 700) begin
            if (done) begin
                pulses++;
                if (done_cyc == 0) begin done_cyc = cyc; busy_at_done = busy; end
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) break;
            if (stop_at >= 0 && beat == stop_at) begin
                pix.in_valid = 1'b0;
                return;
            end
            if (pix.in_ready && (pix.cand_idx !== 4'(beat / 16) || pix.pix_idx !== 4'(beat % 16)))
                idx_err++;
            v = (beat < 256);
            if (stalls && beat == 17 && s17 < 5)   begin v = 1'b0; s17++;  end
            if (stalls && beat == 200 && s200 < 5) begin v = 1'b0; s200++; end
            start = (beat == poke_at);
            gen_pix(mode, beat / 16, beat % 16, cu, rf);
            pix.in_valid = v; pix.cur_pix = cu; pix.ref_pix = rf;
            if (v && pix.in_ready) beat++;
            @(negedge clk); cyc++;
        end
        pix.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (pix.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", pix.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (pix.cand_idx !== 4'd0 || pix.pix_idx !== 4'd0) begin errors++;
            $display("FAIL reset_idx: got c=%0d p=%0d expected 0/0", pix.cand_idx, pix.pix_idx); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (sums[i] !== '0) begin errors++; $display("FAIL reset_sum%0d: got %0d expected 0", i, sums[i]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic run_and_check(input string name, input int mode, input bit stalls, input int poke_at,
                                 input int exp_done);
        int dc, np, ie;
        logic bd;
        drive_block(mode, stalls, -1, poke_at, dc, np, ie, bd);
        checks++; if (dc != exp_done) begin errors++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dc, exp_done); end
        checks++; if (np != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d expected 1", name, np); end
        checks++; if (bd !== 1'b1) begin errors++; $display("FAIL %s_busy_at_done: got %b expected 1", name, bd); end
        checks++; if (busy !== 1'b0 || pix.in_ready !== 1'b0) begin errors++;
            $display("FAIL %s_idle_after: got busy=%b ready=%b expected 0/0", name, busy, pix.in_ready); end
        checks++; if (ie != 0) begin errors++; $display("FAIL %s_idx_track: got %0d bad cycles expected 0", name, ie); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (sums[i] !== SUM_W'(exp_sum(mode, i))) begin errors++;
                $display("FAIL %s_sum%0d: got %0d expected %0d", name, i, sums[i], exp_sum(mode, i)); end
        end
    endtask

    task automatic test_zero_block();     run_and_check("zero", 0, 1'b0, -1, 258); endtask
    task automatic test_per_candidate();  run_and_check("percand", 1, 1'b0, -1, 258); endtask
    task automatic test_max_width();
        run_and_check("max", 2, 1'b0, -1, 258);
        run_and_check("max_swap", 3, 1'b0, -1, 258);
    endtask
    task automatic test_stall();          run_and_check("stall", 1, 1'b1, -1, 268); endtask

    task automatic test_abort();
        int dc, np, ie, dseen;
        logic bd;
        run_and_check("pattern", 4, 1'b0, -1, 258);
        drive_block(2, 1'b0, 40, -1, dc, np, ie, bd);
        checks++; if (pix.cand_idx !== 4'd2 || pix.pix_idx !== 4'd8) begin errors++;
            $display("FAIL abort_pre_idx: got c=%0d p=%0d expected 2/8", pix.cand_idx, pix.pix_idx); end
        abort = 1'b1; pix.in_valid = 1'b1; pix.cur_pix = 8'hFF; pix.ref_pix = 8'h00;
        @(negedge clk);
        abort = 1'b0; pix.in_valid = 1'b0;
        checks++; if (pix.in_ready !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL abort_idle: got ready=%b busy=%b expected 0/0", pix.in_ready, busy); end
        checks++; if (pix.cand_idx !== 4'd0 || pix.pix_idx !== 4'd0) begin errors++;
            $display("FAIL abort_idx: got c=%0d p=%0d expected 0/0", pix.cand_idx, pix.pix_idx); end
        dseen = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) dseen++;
            @(negedge clk);
        end
        checks++; if (dseen != 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles expected 0", dseen); end
        for (int i = 0; i < 16; i++) begin
            int e;
            e = (i < 2) ? 4080 : exp_sum(4, i);
            checks++; if (sums[i] !== SUM_W'(e)) begin errors++;
                $display("FAIL abort_sum%0d: got %0d expected %0d", i, sums[i], e); end
        end
    endtask

    task automatic test_start_ignored();
        run_and_check("start_busy", 1, 1'b0, 10, 258);
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++; if (pix.in_ready !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL start_wins: got ready=%b busy=%b expected 1/1", pix.in_ready, busy); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (pix.in_ready !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL abort_only: got ready=%b busy=%b expected 0/0", pix.in_ready, busy); end
    endtask

    task automatic test_async_reset();
        int dc, np, ie, nz;
        logic bd;
        drive_block(1, 1'b0, 100, -1, dc, np, ie, bd);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pix.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL areset_ctrl: got ready=%b busy=%b done=%b expected 0/0/0", pix.in_ready, busy, done); end
        checks++; if (pix.cand_idx !== 4'd0 || pix.pix_idx !== 4'd0) begin errors++;
            $display("FAIL areset_idx: got c=%0d p=%0d expected 0/0", pix.cand_idx, pix.pix_idx); end
        nz = 0;
        for (int i = 0; i < 16; i++) if (sums[i] !== '0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL areset_sums: got %0d nonzero sums expected 0", nz); end
        @(negedge clk); rst_n = 1'b1;
        run_and_check("after_reset", 4, 1'b0, -1, 258);
    endtask

    initial begin
        pix.in_valid = 1'b0;
        pix.cur_pix  = '0;
        pix.ref_pix  = '0;
        test_reset();
        test_zero_block();
        test_per_candidate();
        test_max_width();
        test_stall();
        test_abort();
        test_start_ignored();
        test_start_abort_idle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sad_accum.md
# sad_accum

- Computes the 16 sums of absolute differences (SADs) for one 4x4 current block against 16 candidate reference positions in the 4x4 search window.
- Sits directly upstream of the minimum-SAD comparator: its `sum0`..`sum15` outputs drive the comparator's sum inputs, and its `done` pulse drives the comparator's `enable`.
- Pixel pairs arrive serially under a valid/ready handshake; the block accumulates one candidate at a time and registers each finished SAD.

## Interface
Parameters:
- PIX_W, 8, pixel width in bits.
- SUM_W, 12, SAD width. Must be >= PIX_W+4; with the defaults the maximum SAD is 16*255 = 4080, so no saturation logic is required.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a new block; honoured only in IDLE.
- abort  in  1  synchronous abandon of the current block.
- in_valid  in  1  cur_pix/ref_pix beat is valid.
- in_ready  out  1  block accepts a beat; equals (state==ACCUM).
- cur_pix  in  PIX_W  current-block pixel.
- ref_pix  in  PIX_W  reference pixel for the current candidate.
- cand_idx  out  4  candidate being accumulated; upstream fetch uses it to address the reference.
- pix_idx  out  4  raster pixel index within the 4x4 block expected next.
- sum0 .. sum15  out  SUM_W each  registered SAD of candidate 0..15.
- busy  out  1  high in ACCUM and DONE.
- done  out  1  one-cycle pulse; all 16 sums valid.

Decided: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- Candidate c maps to motion vector {dy,dx} = {c[3:2], c[1:0]}. Examples: c=4 -> 8'h10, c=15 -> 8'h33. The same mapping is used downstream.
- Beat order is candidate-major: for c = 0..15, pixels p = 0..15 in raster order. One accepted beat is transferred when in_valid && in_ready.
- Per accepted beat: diff = |cur_pix - ref_pix|, computed unsigned at PIX_W+1 bits internally. Then acc <= acc + diff.
- On the beat with p==15:
  - sum[c] <= acc + diff;
  - acc <= 0, p <= 0, c <= c+1.
- FSM:
  - IDLE: start -> ACCUM, with c, p and acc cleared.
  - ACCUM:
    - last beat (c==15, p==15) -> DONE;
    - abort -> IDLE (acc, c and p cleared; sum registers already written this block stay as they are; no done);
    - abort has priority over a simultaneous beat.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- Sum registers hold until overwritten. During the next block, sum[c] changes only when candidate c completes. Downstream samples only on done.
- Stalls (in_valid=0) freeze c, p and acc indefinitely.
- Reset values: state=IDLE; in_ready, busy, done = 0; cand_idx, pix_idx = 0; all sumN = 0; acc = 0.
- Reset asserted mid-block returns everything to these values immediately, independent of clk.

## Timing
- start sampled at edge T in IDLE -> in_ready=1 from T+1.
- sum[c] is visible in the cycle after candidate c's 16th beat is accepted.
- done is high in the cycle after the 256th accepted beat, the same cycle sum15 first shows its new value; busy is still high.
- IDLE is reached the cycle after done; the earliest next start is sampled there.
- Minimum block latency with in_valid held high: start edge to done = 258 cycles (1 to enter ACCUM + 256 beats + 1).
- cand_idx and pix_idx are registered. They show the indices of the next beat to be accepted and update on the same edge as the accepted beat.

## Test plan
- Zero block: cur_pix = ref_pix = 8'h40 for all 256 beats -> all sums 0; done exactly 258 cycles after start; done high one cycle.
- Per-candidate constant: cur=8'h00, ref=c for candidate c -> sumN = 16*N (sum15 = 240); downstream comparator reports mad=0, mv=8'h00.
- Max/width check: cur=8'hFF, ref=8'h00 for all beats -> every sum = 4080 (12'hFF0), no wrap. Swapping cur/ref gives the same result.
- Handshake stall: drop in_valid for 5 cycles at beats 17 and 200 -> identical sums to the no-stall run; done delayed by 10 cycles; cand_idx/pix_idx frozen during the stalls.
- Abort/start: abort on beat 40 (c=2) -> IDLE next cycle, no done, sum0/sum1 hold new values, sum2..15 unchanged. start while busy is ignored. A new start afterwards completes normally.
- Async reset at beat 100 mid-cycle -> all outputs 0 immediately, before the next clk edge. A new start then completes with correct sums.
